// File: rtl/pe_conv_sequencer.sv
// 3-tap / 5-pixel 1-D convolution sequencer sharing one multiplier across taps and outputs.
// Optional build macro PE_PSUM_SAT_EN: saturate emitted psums instead of truncating them.
module pe_conv_sequencer #(
  parameter int DWIDTH     = 8,
  parameter int PSUM_W     = 8,
  parameter int FILT_REUSE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  filt_valid,
  output logic                  filt_ready,
  input  logic [3*DWIDTH-1:0]   filt_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [5*DWIDTH-1:0]   pix_data,
  output logic                  psum_valid,
  input  logic                  psum_ready,
  output logic [PSUM_W-1:0]     psum_data,
  output logic [1:0]            psum_idx,
  output logic                  busy
);

  localparam int ACC_W = 2*DWIDTH + 2;
  localparam int RC_W  = (FILT_REUSE < 2) ? 1 : $clog2(FILT_REUSE + 1);

  typedef enum logic [1:0] {S_FILT, S_PIX, S_MAC, S_OUT} state_e;

  state_e                   state_q;
  logic [DWIDTH-1:0]        w_q   [3];
  logic [DWIDTH-1:0]        pix_q [5];
  logic [1:0]               j_q;
  logic [1:0]               t_q;
  logic [ACC_W-1:0]         acc_q;
  logic [RC_W-1:0]          reuse_cnt_q;
  logic [PSUM_W-1:0]        psum_data_q;

  logic [2:0]               tap_idx;
  logic [2*DWIDTH-1:0]      prod;
  logic [ACC_W-1:0]         acc_d;
  logic [PSUM_W-1:0]        psum_d;

  // NOTE: handshake readies are pure state decodes, forced low while reset is asserted.
  assign filt_ready = rst_n && (state_q == S_FILT);
  assign pix_ready  = rst_n && (state_q == S_PIX);
  assign psum_valid = rst_n && (state_q == S_OUT);
  assign busy       = (state_q == S_MAC) || (state_q == S_OUT);
  assign psum_data  = psum_data_q;
  assign psum_idx   = j_q;

  assign tap_idx = {1'b0, j_q} + {1'b0, t_q};
  assign prod    = pix_q[tap_idx] * w_q[t_q];
  assign acc_d   = acc_q + ACC_W'(prod);

  always_comb begin
`ifdef PE_PSUM_SAT_EN
    if (acc_d > {{(ACC_W-PSUM_W){1'b0}}, {PSUM_W{1'b1}}}) psum_d = '1;
    else                                                   psum_d = acc_d[PSUM_W-1:0];
`else
    psum_d = acc_d[PSUM_W-1:0];
`endif
  end

  // NOTE: all state uses non-blocking assignments; the small weight/pixel arrays are
  // cleared on reset because reset must discard any previously latched operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILT;
      j_q         <= '0;
      t_q         <= '0;
      acc_q       <= '0;
      reuse_cnt_q <= '0;
      psum_data_q <= '0;
      for (int i = 0; i < 3; i++) w_q[i]   <= '0;
      for (int i = 0; i < 5; i++) pix_q[i] <= '0;
    end else begin
      case (state_q)
        S_FILT: if (filt_valid) begin
          for (int i = 0; i < 3; i++) w_q[i] <= filt_data[(2-i)*DWIDTH +: DWIDTH];
          reuse_cnt_q <= '0;
          state_q     <= S_PIX;
        end
        S_PIX: if (pix_valid) begin
          for (int i = 0; i < 5; i++) pix_q[i] <= pix_data[(4-i)*DWIDTH +: DWIDTH];
          j_q     <= '0;
          t_q     <= '0;
          acc_q   <= '0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          acc_q <= acc_d;
          t_q   <= t_q + 2'd1;
          if (t_q == 2'd2) begin
            psum_data_q <= psum_d;
            state_q     <= S_OUT;
          end
        end
        S_OUT: if (psum_ready) begin
          if (j_q != 2'd2) begin
            j_q     <= j_q + 2'd1;
            t_q     <= '0;
            acc_q   <= '0;
            state_q <= S_MAC;
          end else begin
            reuse_cnt_q <= reuse_cnt_q + 1'b1;
            state_q     <= (int'(reuse_cnt_q) + 1 == FILT_REUSE) ? S_FILT : S_PIX;
          end
        end
        default: state_q <= S_FILT;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Self-checking bench for pe_conv_sequencer: directed rows checked against a queue-based convolution model.
module tb_pe_conv_sequencer;

  localparam int DW = 8;
  localparam int PW = 8;
  localparam int FR = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            filt_valid, filt_ready;
  logic [3*DW-1:0] filt_data;
  logic            pix_valid, pix_ready;
  logic [5*DW-1:0] pix_data;
  logic            psum_valid, psum_ready;
  logic [PW-1:0]   psum_data;
  logic [1:0]      psum_idx;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_psum = 0;

  typedef struct { int data; int idx; } psum_t;
  psum_t exp_q[$];
  int    mw [3];
  int    mp [5];
  bit    stall_prev = 0;

  pe_conv_sequencer #(.DWIDTH(DW), .PSUM_W(PW), .FILT_REUSE(FR)) dut (
    .clk(clk), .rst_n(rst_n),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .psum_idx(psum_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Convolution straight from the definition, then the output-width rule.
  function automatic int model_psum(input int j);
    int acc = 0;
    for (int t = 0; t < 3; t++) acc += mp[j+t] * mw[t];
`ifdef PE_PSUM_SAT_EN
    return (acc > (1 << PW) - 1) ? (1 << PW) - 1 : acc;
`else
    return acc % (1 << PW);
`endif
  endfunction

  // Single compare process: every cycle with psum_valid is checked against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (filt_valid && filt_ready)
        for (int i = 0; i < 3; i++) mw[i] = int'(filt_data[(2-i)*DW +: DW]);
      if (pix_valid && pix_ready) begin
        for (int i = 0; i < 5; i++) mp[i] = int'(pix_data[(4-i)*DW +: DW]);
        for (int j = 0; j < 3; j++) exp_q.push_back('{data: model_psum(j), idx: j});
      end
      if (stall_prev) check("hold_valid", psum_valid, 1);
      if (psum_valid) begin
        check("psum_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("psum_data", psum_data, exp_q[0].data);
          check("psum_idx", psum_idx, exp_q[0].idx);
          if (psum_ready) begin
            void'(exp_q.pop_front());
            n_psum++;
          end
        end
      end
      stall_prev = psum_valid && !psum_ready;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // sel 0: pix_ready, 1: filt_ready, 2: psum_valid at idx 1, 3: psum_valid
  task automatic wait_for(input int sel, input string name);
    int n = 0;
    bit hit;
    forever begin
      case (sel)
        0:       hit = pix_ready;
        1:       hit = filt_ready;
        2:       hit = psum_valid && (psum_idx == 2'd1);
        default: hit = psum_valid;
      endcase
      if (hit || n >= 200) break;
      tick;
      n++;
    end
    check(name, hit, 1);
  endtask

  task automatic send_row(input logic [5*DW-1:0] row, output int k);
    pix_data  = row;
    pix_valid = 1'b1;
    wait_for(0, "row_ready_timeout");
    tick;
    k = cyc;
    pix_valid = 1'b0;
  endtask

  function automatic logic [5*DW-1:0] row5(input int a, b, c, d, e);
    return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e)};
  endfunction

  initial begin
    int k, n;
    filt_valid = 0; filt_data = '0;
    pix_valid  = 0; pix_data  = '0;
    psum_ready = 1;

    // Reset state, with readies gated while rst_n is low.
    tick; tick;
    check("rst_filt_ready_gated", filt_ready, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_psum_valid", psum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_psum_data", psum_data, 0);
    check("rst_psum_idx", psum_idx, 0);
    rst_n = 1'b1;
    #1;
    check("rst_filt_ready", filt_ready, 1);

    // Row offered before any filter: stalled until the filter handshake.
    pix_data  = row5(1, 2, 3, 4, 5);
    pix_valid = 1'b1;
    repeat (5) begin
      tick;
      check("pix_stall_no_filter", pix_ready, 0);
    end
    filt_data  = {8'd1, 8'd2, 8'd3};
    filt_valid = 1'b1;
    check("filt_ready_idle", filt_ready, 1);
    tick;
    filt_valid = 1'b0;
    check("pix_ready_after_filt", pix_ready, 1);
    tick;
    k = cyc;
    pix_valid = 1'b0;
    check("busy_in_mac", busy, 1);

    // Row 1: latency and row period.
    n = 0;
    while (!psum_valid && n < 50) begin tick; n++; end
    check("first_psum_latency", n, 3);
    check("row1_psum0_literal", psum_data, 14);
    check("row1_idx0_literal", psum_idx, 0);
    while (!pix_ready && cyc - k < 100) tick;
    check("row_period", cyc - k, 12);
    check("row1_psum2_literal", psum_data, 26);

    // Row 2: backpressure at idx 1.
    send_row(row5(5, 4, 3, 2, 1), k);
    wait_for(2, "idx1_timeout");
    psum_ready = 1'b0;
    repeat (10) begin
      tick;
      check("bp_valid", psum_valid, 1);
      check("bp_idx", psum_idx, 1);
      check("bp_data", psum_data, 16);
    end
    psum_ready = 1'b1;
    tick;
    n = 0;
    while (!psum_valid && n < 50) begin tick; n++; end
    check("post_bp_latency", n, 3);
    check("post_bp_idx", psum_idx, 2);
    check("post_bp_data", psum_data, 10);

    // Row 3 crosses the 8-bit boundary (140, 200, 260); last row for this filter.
    wait_for(0, "row3_ready_timeout");
    send_row(row5(10, 20, 30, 40, 50), k);
    wait_for(1, "refilter_timeout");
    check("psums_after_reuse", n_psum, 9);

    // Fourth row stalls until a new filter arrives.
    pix_data  = row5(255, 255, 255, 255, 255);
    pix_valid = 1'b1;
    repeat (4) begin
      tick;
      check("pix_stall_reuse_done", pix_ready, 0);
    end
    filt_data  = {8'd255, 8'd255, 8'd255};
    filt_valid = 1'b1;
    tick;
    filt_valid = 1'b0;
    tick;
    pix_valid = 1'b0;
    wait_for(3, "max_psum_timeout");
`ifdef PE_PSUM_SAT_EN
    check("max_psum_literal", psum_data, 255);
`else
    check("max_psum_literal", psum_data, 3);
`endif

    // Reset during MAC of idx 1 drops the pending row.
    wait_for(0, "row5_ready_timeout");
    send_row(row5(1, 2, 3, 4, 5), k);
    wait_for(3, "row5_psum0_timeout");
    tick;
    tick;
    check("mid_mac_busy", busy, 1);
    check("mid_mac_idx", psum_idx, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    check("mid_rst_filt_ready", filt_ready, 1);
    check("mid_rst_psum_valid", psum_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_psum_data", psum_data, 0);
    pix_data  = row5(1, 1, 1, 1, 1);
    pix_valid = 1'b1;
    repeat (6) begin
      tick;
      check("post_rst_no_psum", psum_valid, 0);
      check("post_rst_pix_stall", pix_ready, 0);
    end
    filt_data  = {8'd2, 8'd0, 8'd1};
    filt_valid = 1'b1;
    tick;
    filt_valid = 1'b0;
    tick;
    pix_valid = 1'b0;
    wait_for(0, "final_row_timeout");
    check("total_psums", n_psum, 16);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
